subpix_coef_div: RTL

//  Consumer of the column-sum stage. Takes SL/SM/SR (window column sums) plus the

---
 rtl/subpix_coef_div.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/subpix_coef_div.sv
// subpix_coef_div
//   Subpixel edge coefficient stage that follows the column-sum stage.
//   Given window column sums SL/SM/SR and side intensities A/B it produces
//     coef_a = (2*SM - 5*(A+B)) / (2*(A-B))
//     coef_b = (SR - SL)        / (2*(A-B))
//   as signed Q(FRAC) values. Both quotients come from one shared restoring
//   divider that retires one quotient bit per cycle.
//
//   Ports
//     clk, rst               clock (rising edge), async reset active-low
//     in_valid/in_ready      input handshake; ready only while idle
//     SL, SM, SR [10:0]      unsigned column sums
//     A, B [7:0]             unsigned side intensities
//     in_state [3:0]         direction code carried alongside the sample
//     out_valid/out_ready    output handshake; result held until accepted
//     coef_a, coef_b         signed Q(FRAC) coefficients, saturated
//     flat                   |A-B| < EDGE_TH, coefficients forced to 0
//     sat                    either coefficient was clamped
//     out_state [3:0]        direction code of the result
module subpix_coef_div #(
  parameter int FRAC    = 8,
  parameter int OUT_W   = 16,
  parameter int EDGE_TH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [10:0]             SL,
  input  logic [10:0]             SM,
  input  logic [10:0]             SR,
  input  logic [7:0]              A,
  input  logic [7:0]              B,
  input  logic [3:0]              in_state,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] coef_a,
  output logic signed [OUT_W-1:0] coef_b,
  output logic                    flat,
  output logic                    sat,
  output logic [3:0]              out_state
);

  localparam int NW   = 13 + FRAC;         // dividend / quotient width
  localparam int CW   = $clog2(NW);
  localparam int MAXV = (2 ** (OUT_W - 1)) - 1;

  typedef enum logic [2:0] {IDLE, PREP, DIV_A, DIV_B, DONE} state_t;

  state_t            state_q, state_d;
  logic [10:0]       sl_q, sl_d, sm_q, sm_d, sr_q, sr_d;
  logic [7:0]        a_q, a_d, b_q, b_d;
  logic [3:0]        st_q, st_d;
  logic [9:0]        den_q, den_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic              fl_q, fl_d;
  logic [NW-1:0]     nb_dvd_q, nb_dvd_d;   // |Nb|<<FRAC parked until DIV_B
  logic [NW-1:0]     dq_q, dq_d;           // dividend shifts out, quotient in
  logic [9:0]        rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NW-1:0]     qa_q, qa_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  coef_a_q, coef_a_d, coef_b_q, coef_b_d;
  logic              flat_q, flat_d, sat_q, sat_d;
  logic [3:0]        out_state_q, out_state_d;

  // Operand preparation (used in PREP)
  logic [8:0]  d_s;
  logic        d_neg;
  logic [7:0]  d_mag;
  logic [13:0] na_s, na_abs;
  logic [11:0] nb_s, nb_abs;

  always_comb begin
    d_s    = {1'b0, a_q} - {1'b0, b_q};
    d_neg  = d_s[8];
    d_mag  = d_neg ? 8'(-d_s) : d_s[7:0];
    na_s   = {2'b00, sm_q, 1'b0} - 14'd5 * ({6'd0, a_q} + {6'd0, b_q});
    na_abs = na_s[13] ? -na_s : na_s;
    nb_s   = {1'b0, sr_q} - {1'b0, sl_q};
    nb_abs = nb_s[11] ? -nb_s : nb_s;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [10:0]   r2;
  logic          ge;
  logic [9:0]    rem_n;
  logic [NW-1:0] dq_n;

  always_comb begin
    r2    = {rem_q, dq_q[NW-1]};
    ge    = r2 >= {1'b0, den_q};
    rem_n = ge ? 10'(r2 - {1'b0, den_q}) : r2[9:0];
    dq_n  = {dq_q[NW-2:0], ge};
  end

  // Clamp magnitudes and apply signs; a zero quotient stays zero.
  logic             sat_a, sat_b;
  logic [OUT_W-1:0] mag_a, mag_b, res_a, res_b;

  always_comb begin
    sat_a = 32'(qa_q) > 32'(MAXV);
    sat_b = 32'(dq_q) > 32'(MAXV);
    mag_a = sat_a ? OUT_W'(MAXV) : OUT_W'(qa_q);
    mag_b = sat_b ? OUT_W'(MAXV) : OUT_W'(dq_q);
    res_a = sign_a_q ? -mag_a : mag_a;
    res_b = sign_b_q ? -mag_b : mag_b;
  end

  always_comb begin
    state_d     = state_q;
    sl_d        = sl_q;
    sm_d        = sm_q;
    sr_d        = sr_q;
    a_d         = a_q;
    b_d         = b_q;
    st_d        = st_q;
    den_d       = den_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    fl_d        = fl_q;
    nb_dvd_d    = nb_dvd_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    qa_d        = qa_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    coef_a_d    = coef_a_q;
    coef_b_d    = coef_b_q;
    flat_d      = flat_q;
    sat_d       = sat_q;
    out_state_d = out_state_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sl_d       = SL;
          sm_d       = SM;
          sr_d       = SR;
          a_d        = A;
          b_d        = B;
          st_d       = in_state;
          in_ready_d = 1'b0;
          state_d    = PREP;
        end
      end
      PREP: begin
        den_d    = {1'b0, d_mag, 1'b0};
        sign_a_d = na_s[13] ^ d_neg;
        sign_b_d = nb_s[11] ^ d_neg;
        dq_d     = {na_abs[12:0], {FRAC{1'b0}}};
        nb_dvd_d = {1'b0, nb_abs, {FRAC{1'b0}}};
        rem_d    = '0;
        cnt_d    = '0;
        fl_d     = d_mag < 8'(EDGE_TH);
        state_d  = (d_mag < 8'(EDGE_TH)) ? DONE : DIV_A;
      end
      DIV_A: begin
        rem_d = rem_n;
        dq_d  = dq_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NW - 1)) begin
          // Quotient a complete: park it and reload the divider with Nb.
          qa_d    = dq_n;
          dq_d    = nb_dvd_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV_B;
        end
      end
      DIV_B: begin
        rem_d = rem_n;
        dq_d  = dq_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NW - 1))
          state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          // First DONE cycle: publish the result registers.
          out_valid_d = 1'b1;
          out_state_d = st_q;
          flat_d      = fl_q;
          if (fl_q) begin
            coef_a_d = '0;
            coef_b_d = '0;
            sat_d    = 1'b0;
          end else begin
            coef_a_d = res_a;
            coef_b_d = res_b;
            sat_d    = sat_a | sat_b;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sl_q        <= '0;
      sm_q        <= '0;
      sr_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      st_q        <= '0;
      den_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      fl_q        <= 1'b0;
      nb_dvd_q    <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      qa_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      coef_a_q    <= '0;
      coef_b_q    <= '0;
      flat_q      <= 1'b0;
      sat_q       <= 1'b0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      sl_q        <= sl_d;
      sm_q        <= sm_d;
      sr_q        <= sr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      st_q        <= st_d;
      den_q       <= den_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      fl_q        <= fl_d;
      nb_dvd_q    <= nb_dvd_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      qa_q        <= qa_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      coef_a_q    <= coef_a_d;
      coef_b_q    <= coef_b_d;
      flat_q      <= flat_d;
      sat_q       <= sat_d;
      out_state_q <= out_state_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign coef_a    = coef_a_q;
  assign coef_b    = coef_b_q;
  assign flat      = flat_q;
  assign sat       = sat_q;
  assign out_state = out_state_q;

endmodule
